// File: rtl/noc_input_port.sv
// NoC router input stage: flit FIFO plus XY route computation on head flits.
// Holds the route for a whole packet and forwards flits to the demux on grant.
module noc_input_port #(
  parameter int unsigned DEPTH   = 4,
  parameter logic [2:0]  X_COORD = 3'd0,
  parameter logic [2:0]  Y_COORD = 3'd0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [15:0] data_o,
  output logic [2:0]  sel_o,
  output logic        enable_o,
  output logic [4:0]  req_o,
  input  logic        grant_i,
  output logic        err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  localparam logic [2:0] SEL_N = 3'd0;
  localparam logic [2:0] SEL_S = 3'd1;
  localparam logic [2:0] SEL_W = 3'd2;
  localparam logic [2:0] SEL_E = 3'd3;
  localparam logic [2:0] SEL_L = 3'd4;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [AW:0]   count_reg;
  state_t        state_reg;
  logic [2:0]    sel_reg;
  logic          err_reg;

  logic          empty, push, pop, drop, req_active;
  logic [1:0]    head_type;
  logic [2:0]    dst_x, dst_y;
  logic [2:0]    route_sel;

  assign empty     = (count_reg == '0);
  assign ready_o   = rst_ni & (count_reg != FULL_COUNT);
  assign push      = valid_i & ready_o;
  assign data_o    = mem[rd_ptr_reg];
  assign head_type = data_o[15:14];
  assign dst_x     = data_o[13:11];
  assign dst_y     = data_o[10:8];

  // A body or tail flit seen while no packet is open is malformed and discarded.
  assign drop       = (state_reg == IDLE) & ~empty & ~head_type[1];
  assign req_active = (state_reg == ACTIVE) & ~empty;
  assign enable_o   = req_active & grant_i;
  assign pop        = drop | enable_o;

  always_comb begin
    route_sel = SEL_L;
    if (dst_x > X_COORD)      route_sel = SEL_E;
    else if (dst_x < X_COORD) route_sel = SEL_W;
    else if (dst_y > Y_COORD) route_sel = SEL_N;
    else if (dst_y < Y_COORD) route_sel = SEL_S;
  end

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_req
      assign req_o[gi] = req_active & (sel_reg == gi[2:0]);
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_reg] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      sel_reg   <= SEL_N;
      err_reg   <= 1'b0;
    end else begin
      err_reg <= drop;
      case (state_reg)
        IDLE: begin
          if (!empty && head_type[1]) begin
            sel_reg   <= route_sel;
            state_reg <= ACTIVE;
          end
        end
        ACTIVE: begin
          // Tail and single flits close the packet; a stray head is just payload.
          if (enable_o && head_type[0]) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign sel_o = sel_reg;
  assign err_o = err_reg;

endmodule

// File: tb/tb_noc_input_port.sv
// Scoreboard bench for noc_input_port at router coordinate (2,2), DEPTH=4.
module tb_noc_input_port;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [15:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic        grant_i = 1'b0;
  logic        ready_o, enable_o, err_o;
  logic [15:0] data_o;
  logic [2:0]  sel_o;
  logic [4:0]  req_o;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int wcyc = 0;
  int err_cnt = 0;
  logic [18:0] exp_q [$];
  int en_cyc_q [$];

  noc_input_port #(.DEPTH(4), .X_COORD(3'd2), .Y_COORD(3'd2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .sel_o(sel_o), .enable_o(enable_o),
    .req_o(req_o), .grant_i(grant_i), .err_o(err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard: every forwarded flit must match the oldest accepted flit and its route.
  always @(negedge clk) begin
    logic [18:0] e;
    if (rst_ni && err_o) err_cnt++;
    if (rst_ni && enable_o) begin
      en_cyc_q.push_back(cyc);
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL fwd_unexpected: data_o=%h sel_o=%b, required no forward", data_o, sel_o);
      end else begin
        e = exp_q.pop_front();
        if (data_o !== e[15:0] || sel_o !== e[18:16])
          $display("FAIL fwd: data_o=%h sel_o=%b, required data=%h sel=%b", data_o, sel_o, e[15:0], e[18:16]);
        else begin
          pass_cnt++;
          $display("fwd cyc=%0d data=%h sel=%b", cyc, data_o, sel_o);
        end
      end
    end
  end

  function automatic logic [15:0] mk(input logic [1:0] t, input logic [2:0] dx,
                                     input logic [2:0] dy, input logic [7:0] pl);
    return {t, dx, dy, pl};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_flit(input logic [15:0] d, input logic [2:0] s, input bit keep);
    int w = 0;
    valid_i = 1'b1;
    data_i  = d;
    while (!ready_o && w < 50) begin
      step();
      w++;
    end
    if (!ready_o) begin
      total_cnt++;
      $display("FAIL push_timeout: ready_o=%b, required 1", ready_o);
    end else begin
      if (keep) exp_q.push_back({s, d});
      step();
      wcyc = cyc;
    end
  endtask

  task automatic test_reset();
    #1;
    total_cnt += 5;
    if (ready_o !== 1'b0)  $display("FAIL rst_ready: got %b, required 0", ready_o);  else pass_cnt++;
    if (enable_o !== 1'b0) $display("FAIL rst_enable: got %b, required 0", enable_o); else pass_cnt++;
    if (req_o !== 5'b0)    $display("FAIL rst_req: got %b, required 00000", req_o);   else pass_cnt++;
    if (sel_o !== 3'b000)  $display("FAIL rst_sel: got %b, required 000", sel_o);     else pass_cnt++;
    if (err_o !== 1'b0)    $display("FAIL rst_err: got %b, required 0", err_o);       else pass_cnt++;
    step();
    step();
    rst_ni = 1'b1;
    #1;
    total_cnt++;
    if (ready_o !== 1'b1) $display("FAIL rst_release_ready: got %b, required 1", ready_o); else pass_cnt++;
    $display("reset done");
  endtask

  task automatic test_route();
    logic [2:0] dxs [5] = '{3'd3, 3'd1, 3'd2, 3'd2, 3'd2};
    logic [2:0] dys [5] = '{3'd0, 3'd3, 3'd3, 3'd1, 3'd2};
    logic [2:0] sels [5] = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b100};
    logic [4:0] reqs [5] = '{5'b01000, 5'b00100, 5'b00001, 5'b00010, 5'b10000};
    grant_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_flit(mk(2'b11, dxs[i], dys[i], 8'(8'hA0 + i)), sels[i], 1'b1);
      valid_i = 1'b0;
      step();
      total_cnt += 2;
      if (sel_o !== sels[i]) $display("FAIL route_sel%0d: got %b, required %b", i, sel_o, sels[i]); else pass_cnt++;
      if (req_o !== reqs[i]) $display("FAIL route_req%0d: got %b, required %b", i, req_o, reqs[i]); else pass_cnt++;
      $display("route dst=(%0d,%0d) sel=%b req=%b", dxs[i], dys[i], sel_o, req_o);
      grant_i = 1'b1;
      step();
      grant_i = 1'b0;
      step();
    end
  endtask

  task automatic test_packet();
    int head_cyc;
    en_cyc_q.delete();
    grant_i = 1'b1;
    push_flit(mk(2'b10, 3'd3, 3'd2, 8'h10), 3'b011, 1'b1);
    head_cyc = wcyc;
    push_flit(16'h0111, 3'b011, 1'b1);
    push_flit(16'h0222, 3'b011, 1'b1);
    push_flit(16'h4333, 3'b011, 1'b1);
    valid_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    total_cnt++;
    if (en_cyc_q.size() != 4) $display("FAIL pkt_enable_count: got %0d, required 4", en_cyc_q.size());
    else pass_cnt++;
    for (int i = 0; i < en_cyc_q.size() && i < 4; i++) begin
      total_cnt++;
      if (en_cyc_q[i] != head_cyc + 1 + i)
        $display("FAIL pkt_enable_cycle%0d: got %0d, required %0d", i, en_cyc_q[i], head_cyc + 1 + i);
      else pass_cnt++;
    end
    total_cnt++;
    if (req_o !== 5'b0) $display("FAIL pkt_idle_req: got %b, required 00000", req_o); else pass_cnt++;
    grant_i = 1'b0;
    $display("packet done");
  endtask

  task automatic test_full();
    grant_i = 1'b0;
    push_flit(mk(2'b10, 3'd3, 3'd2, 8'h20), 3'b011, 1'b1);
    push_flit(16'h0021, 3'b011, 1'b1);
    push_flit(16'h0022, 3'b011, 1'b1);
    push_flit(16'h0023, 3'b011, 1'b1);
    total_cnt++;
    if (ready_o !== 1'b0) $display("FAIL full_ready: got %b, required 0", ready_o); else pass_cnt++;
    valid_i = 1'b1;
    data_i  = 16'h4024;
    step();
    total_cnt++;
    if (ready_o !== 1'b0) $display("FAIL full_hold: got %b, required 0", ready_o); else pass_cnt++;
    grant_i = 1'b1;
    step();
    grant_i = 1'b0;
    total_cnt++;
    if (ready_o !== 1'b1) $display("FAIL full_release: got %b, required 1", ready_o); else pass_cnt++;
    push_flit(16'h4024, 3'b011, 1'b1);
    valid_i = 1'b0;
    grant_i = 1'b1;
    for (int i = 0; i < 6; i++) step();
    grant_i = 1'b0;
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL full_drain: left %0d, required 0", exp_q.size()); else pass_cnt++;
    $display("full done");
  endtask

  task automatic test_back_to_back();
    grant_i = 1'b0;
    push_flit(mk(2'b10, 3'd1, 3'd2, 8'h30), 3'b010, 1'b1);
    push_flit(16'h0031, 3'b010, 1'b1);
    grant_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_flit(16'(16'h0032 + i), 3'b010, 1'b1);
      total_cnt++;
      if (ready_o !== 1'b1) $display("FAIL b2b_ready%0d: got %b, required 1", i, ready_o); else pass_cnt++;
    end
    push_flit(16'h4038, 3'b010, 1'b1);
    valid_i = 1'b0;
    grant_i = 1'b0;
    en_cyc_q.delete();
    grant_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    grant_i = 1'b0;
    total_cnt++;
    if (en_cyc_q.size() != 2) $display("FAIL b2b_count: remaining %0d, required 2", en_cyc_q.size()); else pass_cnt++;
    $display("back_to_back done");
  endtask

  task automatic test_drop();
    err_cnt = 0;
    grant_i = 1'b1;
    push_flit(16'h0055, 3'b000, 1'b0);
    valid_i = 1'b0;
    step();
    total_cnt++;
    if (err_o !== 1'b1) $display("FAIL drop_err_high: got %b, required 1", err_o); else pass_cnt++;
    step();
    total_cnt++;
    if (err_o !== 1'b0) $display("FAIL drop_err_low: got %b, required 0", err_o); else pass_cnt++;
    push_flit(mk(2'b11, 3'd2, 3'd2, 8'h56), 3'b100, 1'b1);
    valid_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    total_cnt += 2;
    if (err_cnt != 1) $display("FAIL drop_err_len: got %0d cycles, required 1", err_cnt); else pass_cnt++;
    if (exp_q.size() != 0) $display("FAIL drop_next_head: left %0d, required 0", exp_q.size()); else pass_cnt++;
    grant_i = 1'b0;
    $display("drop done");
  endtask

  task automatic test_reset_mid();
    int head_cyc;
    grant_i = 1'b0;
    push_flit(mk(2'b10, 3'd3, 3'd2, 8'h60), 3'b011, 1'b1);
    push_flit(16'h0061, 3'b011, 1'b1);
    push_flit(16'h0062, 3'b011, 1'b1);
    valid_i = 1'b0;
    #2;
    rst_ni  = 1'b0;
    grant_i = 1'b1;
    exp_q.delete();
    #1;
    total_cnt += 4;
    if (enable_o !== 1'b0) $display("FAIL mid_rst_enable: got %b, required 0", enable_o); else pass_cnt++;
    if (req_o !== 5'b0)    $display("FAIL mid_rst_req: got %b, required 00000", req_o);   else pass_cnt++;
    if (sel_o !== 3'b000)  $display("FAIL mid_rst_sel: got %b, required 000", sel_o);     else pass_cnt++;
    if (ready_o !== 1'b0)  $display("FAIL mid_rst_ready: got %b, required 0", ready_o);   else pass_cnt++;
    step();
    rst_ni = 1'b1;
    #1;
    total_cnt += 2;
    if (ready_o !== 1'b1) $display("FAIL mid_rel_ready: got %b, required 1", ready_o); else pass_cnt++;
    if (req_o !== 5'b0)   $display("FAIL mid_rel_empty: req=%b, required 00000", req_o); else pass_cnt++;
    step();
    step();
    en_cyc_q.delete();
    push_flit(mk(2'b11, 3'd1, 3'd3, 8'h63), 3'b010, 1'b1);
    head_cyc = wcyc;
    valid_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    total_cnt++;
    if (en_cyc_q.size() != 1 || en_cyc_q[0] != head_cyc + 1)
      $display("FAIL mid_new_latency: enables=%0d first=%0d, required 1 at %0d",
               en_cyc_q.size(), (en_cyc_q.size() > 0) ? en_cyc_q[0] : -1, head_cyc + 1);
    else pass_cnt++;
    grant_i = 1'b0;
    $display("reset_mid done");
  endtask

  initial begin
    test_reset();
    test_route();
    test_packet();
    test_full();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    step();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL final_queue: left %0d, required 0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/noc_input_port.md
# noc_input_port

Per-port input stage of the NoC router: buffers incoming 16-bit flits in a small FIFO and computes the XY route from each head flit. It drives the 1-to-5 output demux directly with flit data, a 3-bit output select and an enable. It holds the route for the whole packet, requests the selected output from the switch allocator and advances only on grant. One instance sits on each of the five router input ports (N, S, W, E, L).

## Interface
- DEPTH, 4: FIFO depth in flits; power of two, at least 2.
- X_COORD, 3'd0: this router's X coordinate.
- Y_COORD, 3'd0: this router's Y coordinate.

- clk_i  in  1  router clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- data_i  in  16  incoming flit from the link.
- valid_i  in  1  data_i is valid.
- ready_o  out  1  FIFO can accept a flit; a flit is written when valid_i and ready_o are both high.
- data_o  out  16  flit at the FIFO head; goes to the demux data input.
- sel_o  out  3  route held for the packet: 000 N, 001 S, 010 W, 011 E, 100 L.
- enable_o  out  1  flit on data_o is forwarded this cycle; goes to the demux enable.
- req_o  out  5  one-hot output request; bit index equals sel_o.
- grant_i  in  1  switch allocator grants the requested output this cycle.
- err_o  out  1  one-cycle pulse when a malformed flit is dropped.

## Operation
- Flit format:
  - [15:14] type: 10 head, 00 body, 01 tail, 11 single (head and tail).
  - Head/single flits: [13:11] dst_x, [10:8] dst_y, [7:0] payload.
- XY routing, computed on the FIFO head flit:
  - dst_x > X_COORD: E. dst_x < X_COORD: W.
  - Otherwise dst_y > Y_COORD: N. dst_y < Y_COORD: S.
  - Otherwise: L.
  - All comparisons are unsigned, 3 bits.
- FIFO: DEPTH entries with a registered read pointer, write pointer and count (count is log2(DEPTH)+1 bits); pointers wrap modulo DEPTH.
  - ready_o = (count != DEPTH); there is no bypass when full.
  - Push and pop in the same cycle leave count unchanged. This is legal when full only if a pop occurs, but ready_o is still low when full, so no push happens in that cycle.
  - data_o always shows the entry at the read pointer; its value is don't-care when the FIFO is empty.
- FSM states: IDLE, ACTIVE.
  - IDLE, FIFO non-empty, head type 10 or 11: register the route into sel_o and go to ACTIVE. No pop happens in this cycle.
  - IDLE, FIFO non-empty, head type 00 or 01: pop and discard the flit, pulse err_o the next cycle, stay in IDLE.
  - ACTIVE: req_o = onehot(sel_o) while the FIFO is non-empty, else 0. enable_o = ACTIVE & ~empty & grant_i. Pop when enable_o is high.
  - ACTIVE, popped flit type 01 or 11: go to IDLE in the next cycle.
  - ACTIVE, head type 10 (head flit before the tail): forwarded as a body flit; the route does not change.
- sel_o changes only on an IDLE to ACTIVE transition.
- Reset (asynchronous, at any time, including mid-packet):
  - Count and pointers go to 0; buffered flits are lost.
  - state = IDLE, sel_o = 000, req_o = 0, enable_o = 0, err_o = 0.
  - ready_o = 0 while rst_ni is low, 1 in the first cycle after release.

## Timing
- A flit written at edge t is visible on data_o in cycle t+1.
- Head flit at the FIFO head in IDLE during cycle t: sel_o and req_o valid in cycle t+1. The earliest enable_o is in cycle t+1.
- Minimum latency from a head flit's write edge to its demux enable is 2 cycles. Each following flit of the packet can forward 1 cycle after the previous one if grant_i stays high and data is present.
- enable_o and req_o depend combinationally on grant_i, state and the empty flag. data_o and sel_o come from registers only.
- Throughput is 1 flit per cycle within a packet. Each packet boundary costs 1 bubble cycle, for the return to IDLE and the route computation.
- err_o is registered: a high pulse exactly 1 cycle long, in the cycle after the drop.

## Test plan
- Route decode at X_COORD=2, Y_COORD=2, one single flit each:
  - dst (3,0): sel_o=011, req_o=01000.
  - dst (1,3): sel_o=010.
  - dst (2,3): sel_o=000.
  - dst (2,1): sel_o=001.
  - dst (2,2): sel_o=100, req_o=10000.
- 4-flit packet (head to (3,2), 2 body, tail), grant_i held high:
  - enable_o high in 4 consecutive cycles, starting 2 cycles after the head write.
  - sel_o=011 throughout; state returns to IDLE after the tail.
- Full/backpressure, DEPTH=4, grant_i=0, push 5 flits:
  - ready_o low after the 4th write; the 5th flit is held upstream.
  - Raise grant_i for 1 cycle: count goes to 3 and ready_o goes back high.
- Simultaneous push and pop with count=2 under continuous grant: count stays 2, and flits come out in order with wrap-around across pointer 3 to 0.
- Body flit 16'h0055 arriving in IDLE: dropped, err_o high for exactly 1 cycle, no enable_o, and the next head flit routes normally.
- Assert rst_ni low mid-packet with 3 flits buffered:
  - Immediately: enable_o=0, req_o=0, sel_o=000.
  - After release: ready_o=1, FIFO empty, and a new head flit routes with minimum latency.
